// File: rtl/program_loader.sv
// Byte-stream image loader: assembles LE words into instruction memory, verifies an
// XOR checksum, and holds the core in reset until a good image is in place.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

    localparam logic [31:0] MAX_W = MAX_WORDS;

    state_t      state, state_nxt;
    logic        accept;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] n_hdr;
    logic [1:0]  byte_cnt;
    logic [23:0] word_p0;
    logic [15:0] index;
    logic [7:0]  xor_acc;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign n_hdr     = {rx_data, len_lo};
    assign last_word = ({1'b0, index} + 17'd1) == {1'b0, len};

    always_ff @(posedge clk) begin
        if (rst) state <= HDR0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR0: if (accept) state_nxt = HDR1;
            HDR1: begin
                if (accept) begin
                    if ({16'd0, n_hdr} > MAX_W) state_nxt = ERR;
                    else if (n_hdr == 16'd0)    state_nxt = CHK;
                    else                        state_nxt = DATA;
                end
            end
            DATA: if (accept && byte_cnt == 2'd3 && last_word) state_nxt = CHK;
            CHK:  if (accept) state_nxt = (rx_data == xor_acc) ? DONE : ERR;
            default: state_nxt = state;
        endcase
    end

    // rx_ready and cpu_rst are forced to their safe values while rst is held
    always_comb begin
        rx_ready  = 1'b0;
        cpu_rst   = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            HDR0, HDR1, DATA, CHK: rx_ready = !rst;
            DONE: begin
                cpu_rst   = rst;
                load_done = 1'b1;
            end
            ERR:  load_err = 1'b1;
            default: ;
        endcase
    end

    // byte stage: header capture, word assembly, checksum; write stage registered behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_cnt     <= 2'd0;
            word_p0      <= 24'd0;
            index        <= 16'd0;
            xor_acc      <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR0: begin
                        len_lo  <= rx_data;
                        xor_acc <= xor_acc ^ rx_data;
                    end
                    HDR1: begin
                        len     <= n_hdr;
                        xor_acc <= xor_acc ^ rx_data;
                    end
                    DATA: begin
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_p0  <= {rx_data, word_p0[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {rx_data, word_p0};
                            imem_addr    <= BASE_ADDR + {14'd0, index, 2'b00};
                            index        <= index + 16'd1;
                            words_loaded <= index + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, bad checksum, empty, oversize, gapped and
// mid-load-reset frames against hand-computed write/status expectations.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    program_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [7:0] good_stream[11] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                    8'h6F, 8'h00, 8'h00, 8'h00, 8'h6B};
    int acc[$];

    // Drive one byte for one cycle starting just after a negedge; returns the posedge count
    // at which it is sampled.
    task automatic send_byte(input logic [7:0] b, output int c);
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc + 1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_good(input int nbytes, input logic [7:0] last, input bit gaps);
        int c;
        acc.delete();
        for (int i = 0; i < nbytes; i++) begin
            if (gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
            send_byte((i == 10) ? last : good_stream[i], c);
            acc.push_back(c);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq({tag, ".rx_ready_in_rst"}, rx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic check_two_writes(input string tag);
        chk_eq({tag, ".nwrites"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk_eq({tag, ".addr0"}, wr_addr[0], 32'h0000_0000);
            chk_eq({tag, ".data0"}, wr_data[0], 32'h0010_0513);
            chk_eq({tag, ".cyc0"},  wr_cyc[0],  acc[5]);
            chk_eq({tag, ".addr1"}, wr_addr[1], 32'h0000_0004);
            chk_eq({tag, ".data1"}, wr_data[1], 32'h0000_006F);
            chk_eq({tag, ".cyc1"},  wr_cyc[1],  acc[9]);
        end
    endtask

    initial begin
        int c;

        // reset state
        do_reset("rst");
        chk_eq("rst.rx_ready",     rx_ready, 1'b1);
        chk_eq("rst.imem_we",      imem_we, 1'b0);
        chk_eq("rst.imem_addr",    imem_addr, 32'h0);
        chk_eq("rst.imem_wdata",   imem_wdata, 32'h0);
        chk_eq("rst.cpu_rst",      cpu_rst, 1'b1);
        chk_eq("rst.load_done",    load_done, 1'b0);
        chk_eq("rst.load_err",     load_err, 1'b0);
        chk_eq("rst.words_loaded", words_loaded, 16'd0);

        // normal load
        send_good(10, 8'h00, 1'b0);
        chk_eq("norm.cpu_rst_pre",   cpu_rst, 1'b1);
        chk_eq("norm.done_pre",      load_done, 1'b0);
        send_byte(8'h6B, c);
        chk_eq("norm.load_done",     load_done, 1'b1);
        chk_eq("norm.cpu_rst",       cpu_rst, 1'b0);
        chk_eq("norm.load_err",      load_err, 1'b0);
        chk_eq("norm.rx_ready",      rx_ready, 1'b0);
        chk_eq("norm.words_loaded",  words_loaded, 16'd2);
        check_two_writes("norm");

        // bad checksum
        do_reset("bad");
        send_good(11, 8'h6A, 1'b0);
        chk_eq("bad.load_err",  load_err, 1'b1);
        chk_eq("bad.load_done", load_done, 1'b0);
        chk_eq("bad.cpu_rst",   cpu_rst, 1'b1);
        chk_eq("bad.rx_ready",  rx_ready, 1'b0);
        chk_eq("bad.nwrites",   wr_addr.size(), 2);

        // empty image
        do_reset("empty");
        send_byte(8'h00, c);
        send_byte(8'h00, c);
        chk_eq("empty.done_pre", load_done, 1'b0);
        send_byte(8'h00, c);
        repeat (2) @(negedge clk);
        chk_eq("empty.load_done",    load_done, 1'b1);
        chk_eq("empty.cpu_rst",      cpu_rst, 1'b0);
        chk_eq("empty.words_loaded", words_loaded, 16'd0);
        chk_eq("empty.nwrites",      wr_addr.size(), 0);

        // oversize header
        do_reset("over");
        send_byte(8'h01, c);
        chk_eq("over.err_early", load_err, 1'b0);
        send_byte(8'h04, c);
        chk_eq("over.load_err",  load_err, 1'b1);
        chk_eq("over.cpu_rst",   cpu_rst, 1'b1);
        chk_eq("over.rx_ready",  rx_ready, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hAA, c);
        chk_eq("over.nwrites",      wr_addr.size(), 0);
        chk_eq("over.words_loaded", words_loaded, 16'd0);
        chk_eq("over.load_done",    load_done, 1'b0);

        // gapped stream
        do_reset("gap");
        send_good(11, 8'h6B, 1'b1);
        chk_eq("gap.load_done",    load_done, 1'b1);
        chk_eq("gap.cpu_rst",      cpu_rst, 1'b0);
        chk_eq("gap.words_loaded", words_loaded, 16'd2);
        check_two_writes("gap");

        // reset mid-load then full replay
        do_reset("mid");
        send_good(6, 8'h00, 1'b0);
        do_reset("mid2");
        chk_eq("mid.words_cleared", words_loaded, 16'd0);
        chk_eq("mid.imem_we",       imem_we, 1'b0);
        send_good(11, 8'h6B, 1'b0);
        repeat (2) @(negedge clk);
        chk_eq("mid.load_done",    load_done, 1'b1);
        chk_eq("mid.words_loaded", words_loaded, 16'd2);
        check_two_writes("mid");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream, assembles little-endian 32-bit words, and drives a write port into instruction memory starting at BASE_ADDR.
- Holds the single-cycle core in reset (cpu_rst) until a complete, checksum-verified image is loaded, then releases it.
- Sits between the board-level byte source (UART RX / testbench) and the core's top level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned).
- MAX_WORDS, 1024, largest image accepted, in words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse
- imem_addr  out  32  byte address of the write, word-aligned
- imem_wdata  out  32  word to write
- cpu_rst  out  1  core reset, high until load succeeds
- load_done  out  1  image loaded and verified (sticky)
- load_err  out  1  load failed (sticky)
- words_loaded  out  16  count of words written so far

Behaviour:
- Byte accepted on a posedge where rx_valid && rx_ready; otherwise no state change from the byte stream.
- Frame format: LEN_LO, LEN_HI (N = word count, 16-bit LE), then 4*N data bytes (each word LE: first byte = bits 7:0), then CHK = XOR of every preceding frame byte.
- States: HDR0 -> HDR1 -> DATA -> CHK -> DONE | ERR.
  - HDR0: accept LEN_LO -> HDR1.
  - HDR1: accept LEN_HI. N > MAX_WORDS -> ERR. N == 0 -> CHK. Otherwise -> DATA.
  - DATA: byte counter 0..3 shifts into the word register. On the 4th byte, next cycle: imem_we=1, imem_addr=BASE_ADDR+4*index, imem_wdata=word; index and words_loaded += 1. After word N-1 -> CHK.
  - CHK: accept one byte. Equal to running XOR -> DONE; else -> ERR.
  - DONE: load_done=1, cpu_rst=0 from the first cycle in DONE, rx_ready=0.
  - ERR: load_err=1, cpu_rst stays 1, rx_ready=0.
  - DONE and ERR are terminal; only rst leaves them.
- rx_ready = 1 in HDR0, HDR1, DATA and CHK. It is 0 in DONE/ERR and in the cycle of rst.
- Write latency: imem_we is registered and pulses exactly 1 cycle after the 4th byte of a word is accepted. Back-to-back words may produce writes in consecutive-word cycles with no gap required. Byte acceptance is not stalled by the write.
- Running XOR covers LEN_LO, LEN_HI and all data bytes. It is 8-bit and cleared at reset.
- Addresses: index is 16-bit. imem_addr is a 32-bit sum that wraps modulo 2^32 with no error. BASE_ADDR[1:0] must be 0.
- Reset values: rx_ready=0 (1 from the cycle after rst drops), imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0, words_loaded=0, state=HDR0.
- Reset mid-operation: the partial word, counters and XOR are discarded and the state returns to HDR0. Memory contents already written are not cleared. A pending imem_we pulse is suppressed.
- rx_data gaps (rx_valid low) are allowed anywhere in the frame. No timeout.

Test Plan:
- Normal load, BASE_ADDR=0: bytes 02 00 13 05 10 00 6F 00 00 00 6B -> writes (0x0,0x00100513) and (0x4,0x0000006F), each 1 cycle after its 4th byte. words_loaded=2. load_done=1 and cpu_rst=0 the cycle after 6B is accepted.
- Bad checksum: same stream ending 6A -> load_err=1, cpu_rst stays 1, rx_ready=0, load_done=0, both writes still occurred.
- Empty image: 00 00 00 -> no imem_we pulse, load_done=1, words_loaded=0.
- Oversize: 01 04 (N=1025, MAX_WORDS=1024) -> load_err=1 the cycle after LEN_HI, no writes. Further bytes are not accepted.
- Backpressure/gaps: the normal-load stream with rx_valid low for random 0-5 cycles between bytes -> identical writes and completion.
- Reset mid-load: assert rst after 6 bytes of the normal stream, then replay the full stream -> exactly 2 writes after reset with correct data. No write is issued for the partial word. Final load_done=1.
